// File: rtl/prach_marker_delay_line.sv
// Runtime-selectable delay line for the PRACH timing markers: circular RAM buffer,
// table-plus-trim delay, output blanked while the buffer refills after a delay change.
module prach_marker_delay_line #(
  parameter int DATA_W    = 7,
  parameter int MAX_DELAY = 4096,
  parameter int DLY_BW0   = 1825,
  parameter int DLY_BW1   = 1098,
  parameter int DLY_BW2   = 546,
  parameter int DLY_BW3   = 2192,
  localparam int AW       = $clog2(MAX_DELAY)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [3:0]        ch_bw,
  input  logic signed [7:0] delay_trim,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic [AW-1:0]     dly_active,
  output logic              cfg_clamped
);

  typedef logic signed [AW+1:0] req_t;
  typedef enum logic {FILL, RUN} state_t;

  function automatic req_t base_sel(input logic [3:0] bw);
    case (bw)
      4'd0:    base_sel = req_t'(DLY_BW0);
      4'd1:    base_sel = req_t'(DLY_BW1);
      4'd2:    base_sel = req_t'(DLY_BW2);
      default: base_sel = req_t'(DLY_BW3);
    endcase
  endfunction

  function automatic logic is_clamped(input req_t req);
    return (req < req_t'(1)) || (req > req_t'(MAX_DELAY - 1));
  endfunction

  function automatic logic [AW-1:0] sat_delay(input req_t req);
    if (req < req_t'(1))
      sat_delay = AW'(1);
    else if (req > req_t'(MAX_DELAY - 1))
      sat_delay = AW'(MAX_DELAY - 1);
    else
      sat_delay = req[AW-1:0];
  endfunction

  req_t              req;
  logic [AW-1:0]     d_new_p0;
  logic              primed_q;
  state_t            state_q, state_d;
  logic [AW-1:0]     fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]     dly_d;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] mem [MAX_DELAY];
  logic [DATA_W-1:0] mem_rd_p0;
  logic [DATA_W-1:0] byp_p0;
  logic              byp_sel_p0;

  assign req = base_sel(ch_bw) + req_t'(delay_trim);

  // Read one sample ahead of the output register; d_new_p0 already holds the delay
  // that becomes active on a load edge, so the first refilled sample uses it.
  assign rd_addr = wr_ptr - d_new_p0 + AW'(1);

  // The first enabled cycle after reset only primes d_new_p0; the FSM waits for it.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    dly_d      = dly_active;
    if (primed_q) begin
      if (d_new_p0 != dly_active) begin
        dly_d      = d_new_p0;
        fill_cnt_d = '0;
        state_d    = FILL;
      end else if (state_q == FILL) begin
        if (fill_cnt_q == dly_active - AW'(1)) begin
          state_d    = RUN;
          fill_cnt_d = '0;
        end else begin
          fill_cnt_d = fill_cnt_q + AW'(1);
        end
      end
    end
  end

  // Stage p0: delay request, RAM write/read, D=1 bypass capture
  always_ff @(posedge clk) begin
    if (clk_en) begin
      mem[wr_ptr] <= data_in;
      mem_rd_p0   <= mem[rd_addr];
      byp_p0      <= data_in;
      byp_sel_p0  <= (d_new_p0 == AW'(1));
    end
  end

  // Stage p1: control state and blanked output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_new_p0    <= AW'(1);
      primed_q    <= 1'b0;
      cfg_clamped <= 1'b0;
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      dly_active  <= AW'(1);
      wr_ptr      <= '0;
      out_valid   <= 1'b0;
      data_out    <= '0;
    end else if (clk_en) begin
      d_new_p0   <= sat_delay(req);
      primed_q   <= 1'b1;
      if (is_clamped(req))
        cfg_clamped <= 1'b1;
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      dly_active <= dly_d;
      wr_ptr     <= wr_ptr + AW'(1);
      out_valid  <= (state_d == RUN);
      data_out   <= (state_d == RUN) ? (byp_sel_p0 ? byp_p0 : mem_rd_p0) : '0;
    end
  end

endmodule

// File: tb/tb_prach_marker_delay_line.sv
// Randomised bench for prach_marker_delay_line: two instances (default table and
// an overridden table that forces clamping) checked every cycle against a history model.
module tb_prach_marker_delay_line;
  localparam int DATA_W = 7;
  localparam int AW     = 12;

  logic                     clk        = 1'b0;
  logic                     reset      = 1'b1;
  logic                     clk_en     = 1'b0;
  logic [3:0]               ch_bw      = 4'd2;
  logic signed [7:0]        delay_trim = '0;
  logic [DATA_W-1:0]        data_in    = '0;
  logic [DATA_W-1:0]        dout_a, dout_b;
  logic                     vld_a, vld_b, clmp_a, clmp_b;
  logic [AW-1:0]            dly_a, dly_b;

  always #5 clk = ~clk;

  prach_marker_delay_line dut_a (
    .clk(clk), .reset(reset), .clk_en(clk_en), .ch_bw(ch_bw), .delay_trim(delay_trim),
    .data_in(data_in), .data_out(dout_a), .out_valid(vld_a), .dly_active(dly_a),
    .cfg_clamped(clmp_a));

  prach_marker_delay_line #(.DLY_BW2(100), .DLY_BW3(4090)) dut_b (
    .clk(clk), .reset(reset), .clk_en(clk_en), .ch_bw(ch_bw), .delay_trim(delay_trim),
    .data_in(data_in), .data_out(dout_b), .out_valid(vld_b), .dly_active(dly_b),
    .cfg_clamped(clmp_b));

  // Reference: every enabled input is logged by its enabled-cycle index n; the output
  // after cycle n is hist[n-D] once D cycles have passed since the last delay load.
  int                base_tab [2][4] = '{'{1825, 1098, 546, 2192}, '{1825, 1098, 100, 4090}};
  logic [DATA_W-1:0] hist [65536];
  int                n = 0;
  int                m_d [2]    = '{1, 1};
  int                m_dnew [2] = '{1, 1};
  int                m_l [2]    = '{0, 0};
  bit                m_clamp [2];
  bit                m_primed [2];
  bit                e_vld [2];
  int                e_dat [2];

  int  n_chk = 0, n_pass = 0;
  int  pcount = 0;
  int  first_n_a = -1;
  bit  seen_a = 1'b0;
  bit  wrap_phase = 1'b0;
  int  pulses_b = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      n = 0;
      for (int k = 0; k < 2; k++) begin
        m_d[k] = 1; m_dnew[k] = 1; m_l[k] = 0; m_clamp[k] = 1'b0;
        m_primed[k] = 1'b0; e_vld[k] = 1'b0; e_dat[k] = 0;
      end
    end else if (clk_en) begin
      hist[n % 65536] = data_in;
      for (int k = 0; k < 2; k++) begin
        int req;
        if (m_primed[k] && m_dnew[k] != m_d[k]) begin
          m_d[k] = m_dnew[k];
          m_l[k] = n;
        end
        req = base_tab[k][(ch_bw > 4'd3) ? 3 : int'(ch_bw)] + int'(delay_trim);
        if (req < 1) begin
          m_dnew[k] = 1; m_clamp[k] = 1'b1;
        end else if (req > 4095) begin
          m_dnew[k] = 4095; m_clamp[k] = 1'b1;
        end else begin
          m_dnew[k] = req;
        end
        m_primed[k] = 1'b1;
        e_vld[k] = (n >= m_l[k] + m_d[k]);
        e_dat[k] = e_vld[k] ? int'(hist[(n - m_d[k]) % 65536]) : 0;
      end
      n++;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("vld_a",  int'(vld_a),  int'(e_vld[0]));
    chk("dout_a", int'(dout_a), e_dat[0]);
    chk("dly_a",  int'(dly_a),  m_d[0]);
    chk("clmp_a", int'(clmp_a), int'(m_clamp[0]));
    chk("vld_b",  int'(vld_b),  int'(e_vld[1]));
    chk("dout_b", int'(dout_b), e_dat[1]);
    chk("dly_b",  int'(dly_b),  m_d[1]);
    chk("clmp_b", int'(clmp_b), int'(m_clamp[1]));
    if (!reset) begin
      seen_a = 1'b0;
    end else if (!seen_a && vld_a) begin
      seen_a = 1'b1;
      first_n_a = n - 1;
    end
    if (wrap_phase && vld_b && dout_b[6]) begin
      pulses_b++;
      chk("wrap_pos", (n - 1) % 1000, 595);
    end
  end

  task automatic rst_checks();
    chk("rst_vld_a", int'(vld_a), 0);   chk("rst_dout_a", int'(dout_a), 0);
    chk("rst_dly_a", int'(dly_a), 1);   chk("rst_clmp_a", int'(clmp_a), 0);
    chk("rst_vld_b", int'(vld_b), 0);   chk("rst_dout_b", int'(dout_b), 0);
    chk("rst_dly_b", int'(dly_b), 1);   chk("rst_clmp_b", int'(clmp_b), 0);
  endtask

  // Assert reset between clock edges, check outputs at once, release on a falling edge.
  task automatic async_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1 rst_checks();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // en_mode: 0 always on, 1 toggle, 2 random. dmode: 0 random, 1 counter, 2 frm pulse.
  task automatic run(input int cycles, input int en_mode, input int dmode);
    for (int i = 0; i < cycles; i++) begin
      case (en_mode)
        0:       clk_en = 1'b1;
        1:       clk_en = ~clk_en;
        default: clk_en = ($urandom_range(0, 3) != 0);
      endcase
      case (dmode)
        0:       data_in = DATA_W'($urandom);
        1:       data_in = data_in + DATA_W'(1);
        default: data_in = ((pcount % 1000) == 500) ? 7'h40 : 7'h00;
      endcase
      if (clk_en) pcount++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 rst_checks();
    repeat (2) @(negedge clk);
    ch_bw = 4'd2; delay_trim = 8'sd0; data_in = '0;
    reset = 1'b1;
    run(1200, 0, 1);
    chk("s1_dly", int'(dly_a), 546);
    chk("s1_first_valid", first_n_a, 547);
    chk("s1_clamp", int'(clmp_a), 0);

    ch_bw = 4'd0; delay_trim = -8'sd25; clk_en = 1'b0;
    run(4400, 1, 0);
    chk("s2_dly", int'(dly_a), 1800);
    chk("s2_vld", int'(vld_a), 1);

    ch_bw = 4'd1; delay_trim = 8'sd0;
    run(1300, 0, 0);
    chk("s3_run_vld", int'(vld_a), 1);
    chk("s3_run_dly", int'(dly_a), 1098);
    ch_bw = 4'd3;
    run(2, 0, 0);
    chk("s3_drop", int'(vld_a), 0);
    run(2500, 0, 0);
    chk("s3_dly", int'(dly_a), 2192);
    chk("s3_vld", int'(vld_a), 1);

    for (int s = 0; s < 8; s++) begin
      ch_bw = 4'($urandom_range(0, 15));
      delay_trim = 8'($urandom);
      run($urandom_range(20, 2000), 2, 0);
    end

    async_reset();
    ch_bw = 4'd2; delay_trim = -8'sd128;
    run(10, 0, 0);
    chk("lim_dly_a", int'(dly_a), 418);
    chk("lim_clmp_a", int'(clmp_a), 0);
    chk("lim_dly_b", int'(dly_b), 1);
    chk("lim_clmp_b", int'(clmp_b), 1);
    run(200, 0, 0);
    chk("lim_fill_a", int'(vld_a), 0);
    async_reset();
    ch_bw = 4'd2; delay_trim = -8'sd128;
    run(60, 0, 0);
    chk("d1_vld_b", int'(vld_b), 1);
    ch_bw = 4'd1; delay_trim = 8'sd0;
    run(10, 0, 0);
    chk("lim_legal_dly_b", int'(dly_b), 1098);
    chk("lim_sticky_b", int'(clmp_b), 1);

    async_reset();
    ch_bw = 4'd3; delay_trim = 8'sd127; pcount = 0; pulses_b = 0;
    wrap_phase = 1'b1;
    run(16500, 0, 2);
    wrap_phase = 1'b0;
    chk("wrap_dly_b", int'(dly_b), 4095);
    chk("wrap_clmp_b", int'(clmp_b), 1);
    chk("wrap_vld_b", int'(vld_b), 1);
    chk("wrap_pulses", pulses_b, 12);
    chk("wrap_dly_a", int'(dly_a), 2319);
    chk("wrap_clmp_a", int'(clmp_a), 0);

    async_reset();
    ch_bw = 4'd2; delay_trim = 8'sd0; data_in = '0;
    run(700, 0, 1);
    chk("rerun_first_valid", first_n_a, 547);
    chk("rerun_dly", int'(dly_a), 546);
    chk("rerun_vld", int'(vld_a), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
